// File: rtl/recv_check_module_pkg.sv
// Shared definitions for the output-port packet checker.
// Holds the build defaults for bus/field sizing (mirroring the values
// shared with send_module), the err_flags bit indices and the FSM
// state encodings used by recv_check_module.
package recv_check_module_pkg;

    // Default sizing of the switch test build
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int PORT_NUB_TOTAL  = 4;
    localparam int PRIORITY_NUM    = 8;
    localparam int DATA_LENGTH_MAX = 16;

    // err_flags bit positions
    localparam int FLAG_DEST   = 0;
    localparam int FLAG_LEN    = 1;
    localparam int FLAG_DATA   = 2;
    localparam int FLAG_SOP    = 3;
    localparam int FLAG_ORPHAN = 4;

    // Receive FSM states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_DROP    = 2'd2;

endpackage

// File: rtl/recv_sat_counter.sv
// Saturating up-counter used for the good-packet and error counters.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset
//   clr - synchronous clear (wins over inc)
//   inc - count request, ignored once the counter is all-ones
//   cnt - current count
module recv_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt_q <= '0;
        else if (inc && !(&cnt_q))
            cnt_q <= cnt_q + 1'b1;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/recv_check_module.sv
// Per-port packet sink and checker for one output port of the switch.
// Decodes the send_module header beat, checks destination, length and the
// incrementing payload pattern, and keeps saturating counters plus sticky
// error flags for VIO/ILA readout.
// Optional feature macro: RECV_PAYLOAD_CHECK_EN enables payload comparison
// and the DATA flag; without it err_flags[2] stays 0.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   rd_sop/eop/vld/data   - output-port read stream
//   ready                 - sink ready, ~hold
//   hold                  - backpressure request
//   clear                 - clears counters and sticky flags
//   done                  - one-cycle pulse per good packet
//   pkt_cnt, err_cnt      - saturating good / bad packet counts
//   err_flags             - sticky {ORPHAN, SOP, DATA, LEN, DEST}
//   last_src/priority/len - header fields of the last completed packet
module recv_check_module
    import recv_check_module_pkg::*;
#(
    parameter int RX_PORT        = 0,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int WIDTH_SEL      = $clog2(PORT_NUB_TOTAL),
    parameter int WIDTH_PRIORITY = $clog2(PRIORITY_NUM),
    parameter int WIDTH_LENGTH   = $clog2(DATA_LENGTH_MAX)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_sop,
    input  logic                      rd_eop,
    input  logic                      rd_vld,
    input  logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      ready,
    input  logic                      hold,
    input  logic                      clear,
    output logic                      done,
    output logic [31:0]               pkt_cnt,
    output logic [15:0]               err_cnt,
    output logic [4:0]                err_flags,
    output logic [WIDTH_SEL-1:0]      last_src,
    output logic [WIDTH_PRIORITY-1:0] last_priority,
    output logic [WIDTH_LENGTH-1:0]   last_len
);

    // Header layout, LSB first: dest, priority, length, src
    typedef struct packed {
        logic [WIDTH_SEL-1:0]      src;
        logic [WIDTH_LENGTH-1:0]   len;
        logic [WIDTH_PRIORITY-1:0] prio;
        logic [WIDTH_SEL-1:0]      dest;
    } hdr_t;

    localparam int HDR_W = $bits(hdr_t);
    localparam logic [WIDTH_SEL-1:0] RX_SEL = WIDTH_SEL'(RX_PORT);

    logic [1:0]            state_q, state_d;
    hdr_t                  hdr_q, hdr_d, new_hdr, cmp_hdr;
    logic [WIDTH_LENGTH:0] cnt_q, cnt_d;     // one extra bit: never wraps before the LEN check
    logic [4:0]            pflags_q, pflags_d; // in-packet SOP/DATA flags
    logic                  done_q;
    logic [4:0]            flags_q;
    logic [4:0]            cflags;
    logic                  acc, cmpl, len_err, orphan, good, bad;

    assign ready   = ~hold;
    assign acc     = rd_vld & ready;
    assign new_hdr = hdr_t'(rd_data[HDR_W-1:0]);

    always_comb begin
        state_d  = state_q;
        hdr_d    = hdr_q;
        cnt_d    = cnt_q;
        pflags_d = pflags_q;
        cmpl     = 1'b0;
        len_err  = 1'b0;
        orphan   = 1'b0;
        cmp_hdr  = hdr_q;
        if (acc) begin
            if (rd_sop) begin
                // A sop always (re)starts a packet; mid-packet it is flagged
                // against the packet it starts.
                hdr_d    = new_hdr;
                cmp_hdr  = new_hdr;
                cnt_d    = '0;
                pflags_d = '0;
                if (state_q != ST_IDLE)
                    pflags_d[FLAG_SOP] = 1'b1;
                if (rd_eop) begin
                    cmpl    = 1'b1;
                    len_err = (new_hdr.len != '0);
                    state_d = ST_IDLE;
                end else if (new_hdr.len == '0) begin
                    // zero-length header without eop: count already reached
                    cmpl    = 1'b1;
                    len_err = 1'b1;
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end else begin
                case (state_q)
                    ST_PAYLOAD: begin
                        cnt_d = cnt_q + 1'b1;
`ifdef RECV_PAYLOAD_CHECK_EN
                        if (rd_data != DATA_WIDTH'(cnt_q))
                            pflags_d[FLAG_DATA] = 1'b1;
`endif
                        if (rd_eop) begin
                            cmpl    = 1'b1;
                            len_err = (cnt_d != {1'b0, hdr_q.len});
                            state_d = ST_IDLE;
                        end else if (cnt_d == {1'b0, hdr_q.len}) begin
                            cmpl    = 1'b1;
                            len_err = 1'b1;
                            state_d = ST_DROP;
                        end
                    end
                    ST_DROP: begin
                        if (rd_eop)
                            state_d = ST_IDLE;
                    end
                    default: orphan = 1'b1;
                endcase
            end
        end
    end

`ifndef RECV_PAYLOAD_CHECK_EN
    logic unused_data;
    assign unused_data = ^rd_data;
`endif

    always_comb begin
        cflags            = pflags_d;
        cflags[FLAG_LEN]  = len_err;
        cflags[FLAG_DEST] = (cmp_hdr.dest != RX_SEL);
    end

    assign good = cmpl && (cflags == '0);
    assign bad  = (cmpl && (cflags != '0)) || orphan;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            hdr_q         <= '0;
            cnt_q         <= '0;
            pflags_q      <= '0;
            done_q        <= 1'b0;
            flags_q       <= '0;
            last_src      <= '0;
            last_priority <= '0;
            last_len      <= '0;
        end else begin
            state_q  <= state_d;
            hdr_q    <= hdr_d;
            cnt_q    <= cnt_d;
            pflags_q <= pflags_d;
            done_q   <= good & ~clear;
            if (clear)
                flags_q <= '0;
            else
                flags_q <= flags_q | (cmpl ? cflags : 5'b0) | {orphan, 4'b0};
            if (cmpl) begin
                last_src      <= cmp_hdr.src;
                last_priority <= cmp_hdr.prio;
                last_len      <= cmp_hdr.len;
            end
        end
    end

    assign done      = done_q;
    assign err_flags = flags_q;

    recv_sat_counter #(.WIDTH(32)) u_pkt_cnt (
        .clk (clk), .rst (rst), .clr (clear), .inc (good), .cnt (pkt_cnt)
    );

    recv_sat_counter #(.WIDTH(16)) u_err_cnt (
        .clk (clk), .rst (rst), .clr (clear), .inc (bad), .cnt (err_cnt)
    );

endmodule

// File: doc/recv_check_module.md
# recv_check_module

Per-port packet sink and checker for the switch's output side. It consumes the `rd_sop`/`rd_eop`/`rd_vld`/`rd_data` stream of one output port of `top_nxn` and drives that port's `ready`. It decodes the header beat produced by `send_module`, checks destination, length and payload pattern, and keeps saturating good-packet and error counters for VIO/ILA readout. One instance per output port, inside the per-port generate loop of the on-board test top.

## Interface
- `RX_PORT`, default 0: index of the output port this instance is attached to.
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32): data bus width.
- `WIDTH_SEL`, default `$clog2(`PORT_NUB_TOTAL)`: width of the dest and src fields.
- `WIDTH_PRIORITY`, default `$clog2(`PRIORITY)`: width of the priority field.
- `WIDTH_LENGTH`, default `$clog2(`DATA_LENGTH_MAX)`: width of the length field.
- `clk` in 1: single clock (250 MHz external domain).
- `rst` in 1: synchronous, active-high reset.
- `rd_sop` in 1: start of packet; marks the header beat.
- `rd_eop` in 1: end of packet.
- `rd_vld` in 1: beat valid.
- `rd_data` in DATA_WIDTH: beat data.
- `ready` out 1: sink ready; `ready = ~hold`.
- `hold` in 1: VIO backpressure request.
- `clear` in 1: synchronous clear of counters and sticky flags.
- `done` out 1: one-cycle pulse per good packet.
- `pkt_cnt` out 32: good packets received, saturating.
- `err_cnt` out 16: bad packets, saturating.
- `err_flags` out 5: sticky flags {ORPHAN, SOP, DATA, LEN, DEST}, bits [4:0] = DEST, LEN, DATA, SOP, ORPHAN.
- `last_src` out WIDTH_SEL: src field of the last completed packet.
- `last_priority` out WIDTH_PRIORITY: priority of the last completed packet.
- `last_len` out WIDTH_LENGTH: length of the last completed packet.

## Operation
- A beat is accepted when `rd_vld && ready`. Beats are ignored when `ready` is low.
- Header beat layout, LSB first: dest[WIDTH_SEL], priority[WIDTH_PRIORITY], length[WIDTH_LENGTH], src[WIDTH_SEL]. Remaining bits are don't-care.
- `length` is the number of payload beats after the header. Payload beat k (k = 0..length-1) must equal k, zero-extended.
- length = 0: `rd_sop` and `rd_eop` are asserted on the header beat.
- State machine:
  - IDLE
    - accepted beat with sop → capture header, clear beat counter. If eop is also set: complete when length = 0, otherwise LEN error. Else → PAYLOAD.
    - accepted beat without sop → ORPHAN error, stay in IDLE.
  - PAYLOAD
    - each accepted beat increments the beat counter and checks the data.
    - sop on an accepted beat → SOP error; restart on this beat as a new header.
    - eop with beat count ≠ length → LEN error. Otherwise complete.
    - count reaching length without eop → LEN error, → DROP.
  - DROP: discard beats until an accepted eop → IDLE. A sop seen here is handled as in PAYLOAD.
- Completion:
  - good (dest == RX_PORT and no error in the packet): `done` pulses, `pkt_cnt`++.
  - bad: `err_cnt`++ once per packet.
  - ORPHAN counts once per orphan beat.
  - `last_*` update on every completion, good or bad.
- Only the first DATA mismatch in a packet is flagged; checking continues to eop.

## Timing
- `done`, counters, `err_flags` and `last_*` are registered and update on the cycle after the accepted eop beat (or error beat).
- `ready` is combinational from `hold`, with zero latency.
- Reset values: all outputs 0 except `ready`, which follows `~hold`. The FSM resets to IDLE. Reset mid-packet discards the partial packet without counting it.
- `clear` has priority over a same-cycle completion: the completion is not counted, and the FSM is not affected.
- Counters saturate at all-ones and do not wrap.
- The beat counter is WIDTH_LENGTH+1 bits, so it cannot overflow before the LEN check.

## Configuration
- `RECV_PAYLOAD_CHECK_EN`
  - Defined: payload comparison and the DATA flag are active.
  - Undefined: payload is not compared and `err_flags[2]` is tied to 0; dest, length and framing checks are unchanged.

## Structure
- Header field offsets and the `err_flags` bit indices are defined in `generate_parameter.vh` and shared with `send_module`.
- Sub-module `recv_sat_counter` (parameterised width, `inc`/`clr` inputs, saturating) is used for `pkt_cnt` and `err_cnt`.

## Test plan
- RX_PORT = 2; header dest = 2, prio = 5, len = 4, src = 1, then payload 0..3 with eop on the last beat → `done` pulse, `pkt_cnt` = 1, `last_len` = 4, `last_src` = 1, `err_flags` = 0.
- Same packet with dest = 3 → `err_cnt` = 1, `err_flags[0]` = 1, no `done`.
- len = 4 with eop on payload beat 2 → LEN flag set, `err_cnt` = 1. Then a len = 0 packet (sop+eop on one beat) → `pkt_cnt` = 1.
- Payload beat 1 = 0x7 → DATA flag set when `RECV_PAYLOAD_CHECK_EN` is defined; clean `done` when it is undefined.
- `hold` = 1 for 3 cycles mid-packet with `rd_vld` high → those beats are ignored and `ready` = 0. After release, a correctly framed packet → good.
- `rd_vld` without sop in IDLE → ORPHAN flag set, `err_cnt` = 1. Then `clear` asserted in the same cycle as a good eop → all counters 0, no count.
